// File: rtl/execute_in_skid.sv
// execute_in_skid: two-entry skid buffer in front of the execute stage.
// Operands are resolved against the bypass network when an instruction is
// accepted. Entries then leave strictly in order through a main register,
// with one skid register behind it. in_ready comes only from state, so the
// upstream handshake does not depend combinationally on out_ready.
module execute_in_skid #(
  parameter int DATA_W  = 16,
  parameter int E_W     = 6,
  parameter int WC_W    = 2,
  parameter int NUM_BYP = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         IR,
  input  logic [DATA_W-1:0]         npc_in,
  input  logic [E_W-1:0]            E_control,
  input  logic                      Mem_Control_in,
  input  logic [WC_W-1:0]           W_Control_in,
  input  logic [DATA_W-1:0]         VSR1,
  input  logic [DATA_W-1:0]         VSR2,
  input  logic [NUM_BYP-1:0]        byp_sel1,
  input  logic [NUM_BYP-1:0]        byp_sel2,
  input  logic [NUM_BYP*DATA_W-1:0] byp_val,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_IR,
  output logic [DATA_W-1:0]         out_npc,
  output logic [DATA_W-1:0]         out_op1,
  output logic [DATA_W-1:0]         out_op2,
  output logic [E_W-1:0]            out_E_control,
  output logic                      out_Mem_Control,
  output logic [WC_W-1:0]           out_W_Control,
  output logic [1:0]                occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] npc;
    logic [E_W-1:0]    e_ctl;
    logic              mem_ctl;
    logic [WC_W-1:0]   w_ctl;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic [DATA_W-1:0] op1_res, op2_res;
  logic              accept, take;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // Bypass resolution: scan high to low so the lowest-index request wins.
  always_comb begin
    // NOTE: every always_comb target gets a default first; otherwise a path
    // that skips the assignment infers a latch.
    op1_res = VSR1;
    op2_res = VSR2;
    for (int k = NUM_BYP - 1; k >= 0; k--) begin
      if (byp_sel1[k]) op1_res = byp_val[k*DATA_W +: DATA_W];
      if (byp_sel2[k]) op2_res = byp_val[k*DATA_W +: DATA_W];
    end
  end

  // Entry captured from the inputs at accept time.
  always_comb begin
    new_entry.ir      = IR;
    new_entry.npc     = npc_in;
    new_entry.e_ctl   = E_control;
    new_entry.mem_ctl = Mem_Control_in;
    new_entry.w_ctl   = W_Control_in;
    new_entry.op1     = op1_res;
    new_entry.op2     = op2_res;
  end

  // Next-state and storage steering for the EMPTY/ONE/FULL buffer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !take) begin
          skid_d  = new_entry;
          state_d = FULL;
        end else if (take && !accept) begin
          state_d = EMPTY;
        end else if (take && accept) begin
          main_d  = new_entry;
        end
      end
      FULL: begin
        if (take) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every transition. Data registers keep their old
    // contents because output data carries no meaning while out_valid is 0.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (!reset) begin
      state_q <= EMPTY;
      // NOTE: the data registers are cleared as well, because the outputs
      // must read 0 after reset. Without that, they could be left unreset.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_IR          = main_q.ir;
  assign out_npc         = main_q.npc;
  assign out_E_control   = main_q.e_ctl;
  assign out_Mem_Control = main_q.mem_ctl;
  assign out_W_Control   = main_q.w_ctl;
  assign out_op1         = main_q.op1;
  assign out_op2         = main_q.op2;

endmodule

// File: tb/tb_execute_in_skid.sv
// tb_execute_in_skid: scoreboard bench for execute_in_skid.
// Each accepted instruction pushes its hand-computed expected entry into a
// queue. An independent monitor pops and compares every output transfer.
module tb_execute_in_skid;

  localparam int DATA_W  = 16;
  localparam int E_W     = 6;
  localparam int WC_W    = 2;
  localparam int NUM_BYP = 2;

  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] npc;
    logic [E_W-1:0]    e_ctl;
    logic              mem_ctl;
    logic [WC_W-1:0]   w_ctl;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } exp_t;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         IR, npc_in, VSR1, VSR2;
  logic [E_W-1:0]            E_control;
  logic                      Mem_Control_in;
  logic [WC_W-1:0]           W_Control_in;
  logic [NUM_BYP-1:0]        byp_sel1, byp_sel2;
  logic [NUM_BYP*DATA_W-1:0] byp_val;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_IR, out_npc, out_op1, out_op2;
  logic [E_W-1:0]            out_E_control;
  logic                      out_Mem_Control;
  logic [WC_W-1:0]           out_W_Control;
  logic [1:0]                occupancy;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  execute_in_skid #(
    .DATA_W(DATA_W), .E_W(E_W), .WC_W(WC_W), .NUM_BYP(NUM_BYP)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .IR(IR), .npc_in(npc_in), .E_control(E_control),
    .Mem_Control_in(Mem_Control_in), .W_Control_in(W_Control_in),
    .VSR1(VSR1), .VSR2(VSR2),
    .byp_sel1(byp_sel1), .byp_sel2(byp_sel2), .byp_val(byp_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_IR(out_IR), .out_npc(out_npc), .out_op1(out_op1), .out_op2(out_op2),
    .out_E_control(out_E_control), .out_Mem_Control(out_Mem_Control),
    .out_W_Control(out_W_Control), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  always @(negedge clock) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {112'd0, out_IR}, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_IR",          out_IR,          e.ir);
        check("out_npc",         out_npc,         e.npc);
        check("out_E_control",   out_E_control,   e.e_ctl);
        check("out_Mem_Control", out_Mem_Control, e.mem_ctl);
        check("out_W_Control",   out_W_Control,   e.w_ctl);
        check("out_op1",         out_op1,         e.op1);
        check("out_op2",         out_op2,         e.op2);
      end
    end
  end

  // Offer one instruction and wait (bounded) for acceptance. It is called at
  // posedge+1 and returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] ir, input logic [DATA_W-1:0] npc,
                      input logic [E_W-1:0] e, input logic m,
                      input logic [WC_W-1:0] w,
                      input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                      input logic [NUM_BYP-1:0] s1, input logic [NUM_BYP-1:0] s2,
                      input logic [NUM_BYP*DATA_W-1:0] bv,
                      input logic [DATA_W-1:0] exp_op1,
                      input logic [DATA_W-1:0] exp_op2);
    bit done = 0;
    in_valid = 1'b1; IR = ir; npc_in = npc; E_control = e;
    Mem_Control_in = m; W_Control_in = w; VSR1 = v1; VSR2 = v2;
    byp_sel1 = s1; byp_sel2 = s2; byp_val = bv;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        sb.push_back('{ir, npc, e, m, w, exp_op1, exp_op2});
        done = 1;
      end
      @(posedge clock); #1;
    end
    if (!done) check("accept_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
    // Scramble the inputs so that stored entries must not follow them.
    IR = 16'hDEAD; VSR1 = 16'hDEAD; VSR2 = 16'hDEAD; byp_sel1 = '1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clock);
    #1;
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    in_valid = 0; IR = 0; npc_in = 0; E_control = 0; Mem_Control_in = 0;
    W_Control_in = 0; VSR1 = 0; VSR2 = 0; byp_sel1 = 0; byp_sel2 = 0;
    byp_val = 0; flush = 0; out_ready = 0; reset = 0;
    repeat (2) @(posedge clock); #1;
    reset = 1'b1;

    // Reset state.
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_IR",    out_IR,    0);
    check("rst_out_op1",   out_op1,   0);
    @(posedge clock); #1;

    // Single pass with one-cycle latency.
    out_ready = 1'b1;
    send(16'h1234, 16'h0101, 6'h2A, 1'b1, 2'b10, 16'h0005, 16'h0007,
         2'b00, 2'b00, 32'h0, 16'h0005, 16'h0007);
    @(negedge clock);
    check("single_latency_valid", out_valid, 1);
    @(posedge clock); #1;
    drain_wait();

    // Bypass priority: lowest index wins. Then op2 from source 1 only.
    send(16'h2000, 16'h0202, 6'h01, 1'b0, 2'b01, 16'h1111, 16'h2222,
         2'b11, 2'b00, {16'hBBBB, 16'hAAAA}, 16'hAAAA, 16'h2222);
    send(16'h2001, 16'h0203, 6'h3F, 1'b1, 2'b11, 16'h3333, 16'h4444,
         2'b00, 2'b10, {16'hCCCC, 16'h9999}, 16'h3333, 16'hCCCC);
    // Back-to-back sends with out_ready=1 mean simultaneous accept and drain.
    @(negedge clock);
    check("accept_drain_occ", occupancy, 1);
    @(posedge clock); #1;
    drain_wait();

    // Backpressure: A, B buffered, C held, then an in-order drain with no gap.
    out_ready = 1'b0;
    send(16'hA000, 16'h0A0A, 6'h0A, 1'b0, 2'b00, 16'h000A, 16'h00A0,
         2'b00, 2'b00, 32'h0, 16'h000A, 16'h00A0);
    send(16'hB000, 16'h0B0B, 6'h0B, 1'b1, 2'b01, 16'h000B, 16'h00B0,
         2'b01, 2'b00, {16'h5555, 16'h6666}, 16'h6666, 16'h00B0);
    fork
      send(16'hC000, 16'h0C0C, 6'h0C, 1'b0, 2'b10, 16'h000C, 16'h00C0,
           2'b00, 2'b11, {16'h7777, 16'h8888}, 16'h000C, 16'h8888);
      begin
        @(negedge clock);
        check("bp_occupancy", occupancy, 2);
        check("bp_in_ready",  in_ready,  0);
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          check("bp_no_gap", out_valid, 1);
        end
      end
    join
    drain_wait();

    // Flush while FULL with a new entry offered.
    out_ready = 1'b0;
    send(16'hD000, 16'h0D0D, 6'h0D, 1'b0, 2'b00, 16'h000D, 16'h00D0,
         2'b00, 2'b00, 32'h0, 16'h000D, 16'h00D0);
    send(16'hD001, 16'h0D0E, 6'h0E, 1'b0, 2'b00, 16'h001D, 16'h01D0,
         2'b00, 2'b00, 32'h0, 16'h001D, 16'h01D0);
    flush = 1'b1; in_valid = 1'b1; IR = 16'hEEEE;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    check("flush_occupancy", occupancy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready",  in_ready,  1);
    out_ready = 1'b1;
    repeat (3) @(posedge clock); #1;   // monitor flags any leftover output

    // Reset while FULL, then a single pass.
    out_ready = 1'b0;
    send(16'hF000, 16'h0F0F, 6'h0F, 1'b1, 2'b11, 16'hF00D, 16'hF00E,
         2'b00, 2'b00, 32'h0, 16'hF00D, 16'hF00E);
    send(16'hF001, 16'h0F10, 6'h10, 1'b1, 2'b11, 16'hF01D, 16'hF01E,
         2'b00, 2'b00, 32'h0, 16'hF01D, 16'hF01E);
    do_reset();
    @(negedge clock);
    check("rst2_occupancy", occupancy, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready",  in_ready,  1);
    check("rst2_out_IR",    out_IR,    0);
    check("rst2_out_npc",   out_npc,   0);
    check("rst2_out_op2",   out_op2,   0);
    check("rst2_out_W",     out_W_Control, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(16'h1234, 16'h0101, 6'h2A, 1'b1, 2'b10, 16'h0005, 16'h0007,
         2'b00, 2'b00, 32'h0, 16'h0005, 16'h0007);
    @(negedge clock);
    check("rst2_single_valid", out_valid, 1);
    @(posedge clock); #1;
    drain_wait();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
